// File: rtl/sha256_seq_pkg.sv
// Shared definitions for the SHA-256 message sequencer:
// FSM state codes, block kinds and block geometry constants.
package sha256_seq_pkg;

  localparam logic [1:0] FILL      = 2'd0;
  localparam logic [1:0] WAIT_CORE = 2'd1;
  localparam logic [1:0] SEND      = 2'd2;
  localparam logic [1:0] GAP       = 2'd3;

  typedef enum logic [1:0] {
    DATA,
    FINAL,
    SPILL,
    TAIL
  } kind_t;

  localparam int         BLK_BYTES = 64;
  localparam int         LEN_POS   = 56;
  localparam logic [7:0] PAD_BYTE  = 8'h80;

endpackage

// File: rtl/sha_block_buf.sv
// 64x8 block buffer: one synchronous write port, one
// combinational read port.
module sha_block_buf
  import sha256_seq_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [5:0] waddr,
  input  logic [7:0] wdata,
  input  logic [5:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [BLK_BYTES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sha256_msg_sequencer.sv
// Buffers message bytes into 64-byte blocks, applies SHA-256
// padding and streams each block to a byte-serial core.
module sha256_msg_sequencer
  import sha256_seq_pkg::*;
#(
  parameter int LEN_W   = 32,
  parameter int GAP_CYC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       core_busy,
  output logic [7:0] core_data,
  output logic       core_write_enable,
  output logic       core_first_block,
  output logic       core_last_block,
  output logic       msg_done
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  logic [1:0]       state;
  kind_t            kind;
  logic [6:0]       pos;
  logic [5:0]       idx;
  logic [GW-1:0]    gcnt;
  logic [LEN_W-1:0] byte_cnt;
  logic             msg_first;

  logic       xfer;
  logic [6:0] pos_nx;
  logic       gap_end;
  logic       sending;
  logic       lastish;
  logic [7:0] rd;
  logic [63:0] len64;
  logic [7:0] len_byte;
  logic       in_rng;
  logic       at_pad;
  logic       is_len;
  logic       sel_buf;
  logic       sel_pad;
  logic       sel_len;

  assign in_ready = reset & (state == FILL);
  assign xfer     = in_valid & in_ready;
  assign pos_nx   = pos + 7'd1;
  assign gap_end  = gcnt == GW'(GAP_CYC - 1);
  assign sending  = state == SEND;
  assign lastish  = (kind == FINAL) | (kind == TAIL);

  sha_block_buf u_buf (
    .clk   (clk),
    .we    (xfer),
    .waddr (pos[5:0]),
    .wdata (in_data),
    .raddr (idx),
    .rdata (rd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FILL;
      kind      <= DATA;
      pos       <= '0;
      idx       <= '0;
      gcnt      <= '0;
      byte_cnt  <= '0;
      msg_first <= 1'b1;
      msg_done  <= 1'b0;
    end else begin
      msg_done <= 1'b0;
      unique case (state)
        FILL: begin
          if (xfer) begin
            pos      <= pos_nx;
            byte_cnt <= byte_cnt + LEN_W'(1);
            if (in_last) begin
              kind  <= (pos_nx < 7'(LEN_POS)) ? FINAL : SPILL;
              state <= WAIT_CORE;
            end else if (pos_nx == 7'(BLK_BYTES)) begin
              kind  <= DATA;
              state <= WAIT_CORE;
            end
          end
        end
        WAIT_CORE: begin
          if (!core_busy) begin
            state <= SEND;
            idx   <= '0;
          end
        end
        SEND: begin
          idx       <= idx + 6'd1;
          msg_first <= 1'b0;
          if (idx == 6'd63) begin
            state    <= GAP;
            gcnt     <= '0;
            msg_done <= lastish;
          end
        end
        GAP: begin
          gcnt <= gcnt + GW'(1);
          if (gap_end) begin
            if (kind == SPILL) begin
              kind  <= TAIL;
              state <= WAIT_CORE;
            end else begin
              state <= FILL;
              pos   <= '0;
              if (kind != DATA) begin
                msg_first <= 1'b1;
                byte_cnt  <= '0;
              end
            end
          end
        end
      endcase
    end
  end

  // Message length in bits, sent most significant byte first.
  assign len64    = 64'({byte_cnt, 3'b000});
  assign len_byte = 8'(len64 >> {6'd63 - idx, 3'b000});

  assign in_rng = {1'b0, idx} < pos;
  assign at_pad = {1'b0, idx} == pos;
  assign is_len = idx >= 6'(LEN_POS);

  assign sel_buf = (kind == DATA) | ((kind != TAIL) & in_rng);
  assign sel_pad = ~sel_buf &
    ((((kind == FINAL) | (kind == SPILL)) & at_pad) |
     ((kind == TAIL) & (idx == 6'd0) & (pos == 7'(BLK_BYTES))));
  assign sel_len = ~sel_buf & ~sel_pad & is_len & lastish;

  always_comb begin
    core_data = '0;
    unique case (1'b1)
      sel_buf: core_data = rd;
      sel_pad: core_data = PAD_BYTE;
      sel_len: core_data = len_byte;
      default: core_data = '0;
    endcase
    if (!sending) core_data = '0;
  end

  assign core_write_enable = sending;
  assign core_first_block  = sending & (idx == 6'd0) & msg_first;
  assign core_last_block   = sending & (idx == 6'd0) & lastish;

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Directed bench for sha256_msg_sequencer: sends messages and
// compares every block issued to the core against hand-built bytes.
module tb_sha256_msg_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       core_busy = 1'b0;
  logic [7:0] core_data;
  logic       core_write_enable;
  logic       core_first_block;
  logic       core_last_block;
  logic       msg_done;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  logic [7:0] got [64];
  logic [7:0] exp_blk [64];
  logic       got_ok, got_fb, got_lb, got_ferr, got_done, got_gap_we;
  int         got_start;

  sha256_msg_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_last           (in_last),
    .in_ready          (in_ready),
    .core_busy         (core_busy),
    .core_data         (core_data),
    .core_write_enable (core_write_enable),
    .core_first_block  (core_first_block),
    .core_last_block   (core_last_block),
    .msg_done          (msg_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] msg_byte(input int pat, input int i);
    if (pat == 0) return 8'h30;
    if (pat == 1) return 8'h61 + 8'(i % 26);
    return 8'(i);
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < 64; i++)
      if (got[i] !== exp_blk[i]) return i;
    return -1;
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < 64; i++) exp_blk[i] = 8'h00;
  endtask

  task automatic send_msg(input int len, input int pat);
    int t;
    for (int i = 0; i < len; i++) begin
      t = 0;
      in_data  = msg_byte(pat, i);
      in_valid = 1'b1;
      in_last  = (i == len - 1);
      while (!in_ready && t < 4000) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        checks++;
        $display("FAIL send_timeout: byte %0d in_ready=%0b required 1", i, in_ready);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_block();
    int t;
    t = 0;
    got_ok = 1'b0;
    got_done = 1'b0;
    got_gap_we = 1'b0;
    while (!core_write_enable && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (!core_write_enable) begin
      $display("FAIL block_timeout: core_write_enable=0 after %0d cycles required 1", t);
      for (int i = 0; i < 64; i++) got[i] = 8'hxx;
      return;
    end
    got_ok    = 1'b1;
    got_start = cyc;
    got_fb    = core_first_block;
    got_lb    = core_last_block;
    got_ferr  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) @(negedge clk);
      got[i] = core_data;
      if (!core_write_enable) got_ferr = 1'b1;
      if (i > 0 && (core_first_block || core_last_block)) got_ferr = 1'b1;
    end
    @(negedge clk);
    got_done   = msg_done;
    got_gap_we = core_write_enable;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, core_write_enable, core_first_block, core_last_block,
         msg_done, core_data} !== 13'd0)
      $display("FAIL reset_outputs: got %b required all 0",
        {in_ready, core_write_enable, core_first_block, core_last_block, msg_done, core_data});
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, core_write_enable, msg_done} !== 3'b100)
      $display("FAIL reset_release: in_ready/we/done=%b required 100",
        {in_ready, core_write_enable, msg_done});
    else passed++;
  endtask

  task automatic test_spill_56();
    int d;
    send_msg(56, 0);
    get_block();
    clear_exp();
    for (int i = 0; i < 56; i++) exp_blk[i] = 8'h30;
    exp_blk[56] = 8'h80;
    d = first_diff();
    checks++;
    if (d != -1) $display("FAIL spill56_blk1: byte %0d got %h required %h", d, got[d], exp_blk[d]);
    else passed++;
    checks++;
    if ({got_ok, got_fb, got_lb, got_ferr, got_done, got_gap_we} !== 6'b110000)
      $display("FAIL spill56_blk1_flags: got %b required 110000",
        {got_ok, got_fb, got_lb, got_ferr, got_done, got_gap_we});
    else passed++;
    get_block();
    clear_exp();
    exp_blk[62] = 8'h01;
    exp_blk[63] = 8'hC0;
    d = first_diff();
    checks++;
    if (d != -1) $display("FAIL spill56_blk2: byte %0d got %h required %h", d, got[d], exp_blk[d]);
    else passed++;
    checks++;
    if ({got_ok, got_fb, got_lb, got_ferr, got_done, got_gap_we} !== 6'b101010)
      $display("FAIL spill56_blk2_flags: got %b required 101010",
        {got_ok, got_fb, got_lb, got_ferr, got_done, got_gap_we});
    else passed++;
  endtask

  task automatic busy_window(input string name, input int n);
    int bad;
    bad = 0;
    core_busy = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (core_write_enable) bad++;
    end
    core_busy = 1'b0;
    checks++;
    if (bad != 0) $display("FAIL %s: %0d write cycles while busy, required 0", name, bad);
    else passed++;
  endtask

  task automatic test_busy_pacing();
    int d;
    fork
      send_msg(120, 0);
      begin
        get_block();
        for (int i = 0; i < 64; i++) exp_blk[i] = 8'h30;
        d = first_diff();
        checks++;
        if (d != -1 || {got_ok, got_fb, got_lb, got_ferr, got_done} !== 5'b11000)
          $display("FAIL m120_blk1: diff at %0d flags %b required -1 and 11000",
            d, {got_ok, got_fb, got_lb, got_ferr, got_done});
        else passed++;
        busy_window("m120_busy1", 80);
        get_block();
        clear_exp();
        for (int i = 0; i < 56; i++) exp_blk[i] = 8'h30;
        exp_blk[56] = 8'h80;
        d = first_diff();
        checks++;
        if (d != -1 || {got_ok, got_fb, got_lb, got_ferr, got_done} !== 5'b10000)
          $display("FAIL m120_blk2: diff at %0d flags %b required -1 and 10000",
            d, {got_ok, got_fb, got_lb, got_ferr, got_done});
        else passed++;
        busy_window("m120_busy2", 80);
        get_block();
        clear_exp();
        exp_blk[62] = 8'h03;
        exp_blk[63] = 8'hC0;
        d = first_diff();
        checks++;
        if (d != -1 || {got_ok, got_fb, got_lb, got_ferr, got_done} !== 5'b10101)
          $display("FAIL m120_blk3: diff at %0d flags %b required -1 and 10101",
            d, {got_ok, got_fb, got_lb, got_ferr, got_done});
        else passed++;
      end
    join
  endtask

  task automatic test_single_block();
    int d;
    send_msg(55, 1);
    get_block();
    clear_exp();
    for (int i = 0; i < 55; i++) exp_blk[i] = 8'h61 + 8'(i % 26);
    exp_blk[55] = 8'h80;
    exp_blk[62] = 8'h01;
    exp_blk[63] = 8'hB8;
    d = first_diff();
    checks++;
    if (d != -1) $display("FAIL single55: byte %0d got %h required %h", d, got[d], exp_blk[d]);
    else passed++;
    checks++;
    if ({got_ok, got_fb, got_lb, got_ferr, got_done, got_gap_we} !== 6'b111010)
      $display("FAIL single55_flags: got %b required 111010",
        {got_ok, got_fb, got_lb, got_ferr, got_done, got_gap_we});
    else passed++;
    @(negedge clk);
    checks++;
    if (msg_done !== 1'b0) $display("FAIL single55_done_pulse: msg_done=%b required 0", msg_done);
    else passed++;
  endtask

  task automatic test_exact_64();
    int d;
    send_msg(64, 2);
    get_block();
    for (int i = 0; i < 64; i++) exp_blk[i] = 8'(i);
    d = first_diff();
    checks++;
    if (d != -1 || {got_ok, got_fb, got_lb, got_ferr, got_done} !== 5'b11000)
      $display("FAIL exact64_blk1: diff at %0d flags %b required -1 and 11000",
        d, {got_ok, got_fb, got_lb, got_ferr, got_done});
    else passed++;
    get_block();
    clear_exp();
    exp_blk[0]  = 8'h80;
    exp_blk[62] = 8'h02;
    d = first_diff();
    checks++;
    if (d != -1 || {got_ok, got_fb, got_lb, got_ferr, got_done} !== 5'b10101)
      $display("FAIL exact64_blk2: diff at %0d flags %b required -1 and 10101",
        d, {got_ok, got_fb, got_lb, got_ferr, got_done});
    else passed++;
  endtask

  task automatic test_busy_hold();
    int d, bad, fall;
    core_busy = 1'b1;
    send_msg(10, 1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (core_write_enable || in_ready) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL hold_busy: %0d cycles with we or in_ready, required 0", bad);
    else passed++;
    core_busy = 1'b0;
    fall = cyc;
    get_block();
    checks++;
    if (got_start - fall !== 1)
      $display("FAIL hold_first_write: latency %0d required 1", got_start - fall);
    else passed++;
    clear_exp();
    for (int i = 0; i < 10; i++) exp_blk[i] = 8'h61 + 8'(i);
    exp_blk[10] = 8'h80;
    exp_blk[63] = 8'h50;
    d = first_diff();
    checks++;
    if (d != -1 || {got_ok, got_fb, got_lb, got_ferr, got_done} !== 5'b11101)
      $display("FAIL hold_block: diff at %0d flags %b required -1 and 11101",
        d, {got_ok, got_fb, got_lb, got_ferr, got_done});
    else passed++;
  endtask

  task automatic test_reset_mid_send();
    int d, t;
    send_msg(30, 0);
    t = 0;
    while (!core_write_enable && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (20) @(negedge clk);
    checks++;
    if ({core_write_enable, core_data} !== 9'h130)
      $display("FAIL abort_i20: we/data=%h required 130", {core_write_enable, core_data});
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, core_write_enable, core_first_block, core_last_block,
         msg_done, core_data} !== 13'd0)
      $display("FAIL abort_outputs: got %b required all 0",
        {in_ready, core_write_enable, core_first_block, core_last_block, msg_done, core_data});
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, core_write_enable} !== 2'b10)
      $display("FAIL abort_release: in_ready/we=%b required 10", {in_ready, core_write_enable});
    else passed++;
    send_msg(3, 1);
    get_block();
    clear_exp();
    exp_blk[0]  = 8'h61;
    exp_blk[1]  = 8'h62;
    exp_blk[2]  = 8'h63;
    exp_blk[3]  = 8'h80;
    exp_blk[63] = 8'h18;
    d = first_diff();
    checks++;
    if (d != -1 || {got_ok, got_fb, got_lb, got_ferr, got_done} !== 5'b11101)
      $display("FAIL abort_next_msg: diff at %0d flags %b required -1 and 11101",
        d, {got_ok, got_fb, got_lb, got_ferr, got_done});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_spill_56();
    test_busy_pacing();
    test_single_block();
    test_exact_64();
    test_busy_hold();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
